// File: rtl/pwm_duty_decoder.sv
// Recovers a signed duty value from an H-bridge PWM pair (A forward, B reverse),
// one result per trigger-delimited window, with shoot-through and missing-trigger flags.
module pwm_duty_decoder #(
    parameter int PWM_PERIOD_CYCLES = 100,
    parameter int DATA_WIDTH        = 16,
    parameter int CNT_WIDTH         = $clog2(2*PWM_PERIOD_CYCLES+1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trigger,
    input  logic                         pwm_in_a,
    input  logic                         pwm_in_b,
    output logic signed [DATA_WIDTH-1:0] duty_source_data,
    output logic                         duty_source_valid,
    output logic                         status_shoot_through,
    output logic                         status_overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(2*PWM_PERIOD_CYCLES);

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic en);
        if (en && (cnt != CNT_MAX))
            return cnt + CNT_WIDTH'(1);
        return cnt;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] fit_width(input logic signed [CNT_WIDTH:0] d);
        logic signed [DATA_WIDTH+CNT_WIDTH:0] wide;
        wide = {{DATA_WIDTH{d[CNT_WIDTH]}}, d};
        return wide[DATA_WIDTH-1:0];
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous PWM pins
    logic a_p0, a_p1, b_p0, b_p1;

    always_ff @(posedge clk) begin
        a_p0 <= pwm_in_a;
        a_p1 <= a_p0;
        b_p0 <= pwm_in_b;
        b_p1 <= b_p0;
    end

    logic sa, sb, a_only, b_only;
    assign sa     = a_p1;
    assign sb     = b_p1;
    assign a_only = sa & ~sb;
    assign b_only = sb & ~sa;

    // Stage p2: window accumulation and result register
    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          cnt_a_q, cnt_b_q, cnt_win_q;
    logic [CNT_WIDTH-1:0]          cnt_a_d, cnt_b_d, cnt_win_d;
    logic                          valid_d, overrun_d, shoot_d;
    logic signed [DATA_WIDTH-1:0]  data_d;
    logic signed [CNT_WIDTH:0]     diff;

    assign diff = $signed({1'b0, cnt_a_q}) - $signed({1'b0, cnt_b_q});

    always_comb begin
        state_d   = state_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        cnt_win_d = cnt_win_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        data_d    = duty_source_data;
        shoot_d   = status_shoot_through | (sa & sb);

        case (state_q)
            IDLE: begin
                cnt_a_d   = '0;
                cnt_b_d   = '0;
                cnt_win_d = '0;
                if (trigger) begin
                    state_d   = MEASURE;
                    cnt_a_d   = sat_inc('0, a_only);
                    cnt_b_d   = sat_inc('0, b_only);
                    cnt_win_d = sat_inc('0, 1'b1);
                end
            end
            MEASURE: begin
                if (trigger) begin
                    // The trigger-cycle sample opens the next window, not the closing one
                    valid_d   = 1'b1;
                    data_d    = fit_width(diff);
                    cnt_a_d   = sat_inc('0, a_only);
                    cnt_b_d   = sat_inc('0, b_only);
                    cnt_win_d = sat_inc('0, 1'b1);
                end else if (cnt_win_q == CNT_MAX) begin
                    overrun_d = 1'b1;
                    state_d   = IDLE;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                    cnt_win_d = '0;
                end else begin
                    cnt_a_d   = sat_inc(cnt_a_q, a_only);
                    cnt_b_d   = sat_inc(cnt_b_q, b_only);
                    cnt_win_d = sat_inc(cnt_win_q, 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= IDLE;
            cnt_a_q              <= '0;
            cnt_b_q              <= '0;
            cnt_win_q            <= '0;
            duty_source_valid    <= 1'b0;
            duty_source_data     <= '0;
            status_shoot_through <= 1'b0;
            status_overrun       <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_a_q              <= cnt_a_d;
            cnt_b_q              <= cnt_b_d;
            cnt_win_q            <= cnt_win_d;
            duty_source_valid    <= valid_d;
            duty_source_data     <= data_d;
            status_shoot_through <= shoot_d;
            status_overrun       <= overrun_d;
        end
    end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
Decodes a two-wire H-bridge PWM pair (A = forward drive, B = reverse drive) back into a signed duty value once per trigger-delimited PWM period. It is the inverse of pwm_driver's duty-to-PWM encoding. It taps the driver_pwm pins for loopback self-check and emits a valid-qualified source stream with the same format pwm_driver accepts on its sink. It also flags shoot-through (A and B high together) and missing triggers.

Parameters:
PWM_PERIOD_CYCLES, 100, nominal clk cycles between triggers; sets counter saturation and overrun limit
DATA_WIDTH, 16, width of signed duty output
CNT_WIDTH, $clog2(2*PWM_PERIOD_CYCLES+1), internal counter width (derived, do not override)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
trigger  input  1  one-cycle pulse marking PWM period start (same trigger fed to pwm_driver)
pwm_in_a  input  1  forward-drive PWM, asynchronous to clk
pwm_in_b  input  1  reverse-drive PWM, asynchronous to clk
duty_source_data  output  DATA_WIDTH  signed duty of last completed window (two's complement)
duty_source_valid  output  1  one-cycle qualifier for duty_source_data
status_shoot_through  output  1  sticky: A and B sampled high in the same cycle
status_overrun  output  1  one-cycle pulse: window exceeded limit without trigger

Behaviour:
- Reset values: duty_source_data = 0, duty_source_valid = 0, status_shoot_through = 0, status_overrun = 0. All counters cleared. State = IDLE.
- pwm_in_a/b pass through a 2-flop synchronizer. Only the synchronized values sa/sb are used below. Latency is 2 clk.
- Counters: cnt_a counts cycles with sa&~sb. cnt_b counts cycles with sb&~sa. cnt_win counts all cycles in the window. All saturate at 2*PWM_PERIOD_CYCLES.
- State machine:
  - IDLE: counters held at 0. trigger -> MEASURE. The trigger cycle is sample 1 of the new window. No output.
  - MEASURE, trigger=1: the previous window closes. The sample in the trigger cycle belongs to the new window. In the next cycle, duty_source_valid=1 and duty_source_data = sign-extended (cnt_a - cnt_b) of the closed window. Counters restart with the trigger-cycle sample. Stay in MEASURE.
  - MEASURE, trigger=0 and cnt_win reaches 2*PWM_PERIOD_CYCLES: status_overrun pulses for 1 cycle. No valid. -> IDLE.
  - Trigger and the overrun condition in the same cycle: trigger wins. The window is emitted normally and there is no overrun pulse.
- duty_source_data holds its value between valids. Consumers qualify it with valid only.
- Window of exactly PWM_PERIOD_CYCLES with A high throughout gives +PWM_PERIOD_CYCLES. B high throughout gives -PWM_PERIOD_CYCLES.
- Both-high cycles increment neither cnt_a nor cnt_b. They set status_shoot_through in the next cycle. The flag stays set until reset and does not suppress output.
- Subtraction is done at CNT_WIDTH+1 bits signed, then sign-extended or truncated to DATA_WIDTH. With default parameters no truncation occurs.
- Back-to-back triggers (1-cycle window): emits the result of that 1-sample window. This is legal.
- Reset mid-window: the window is discarded with no valid. The state returns to IDLE and the sticky flag clears. The first trigger after reset only opens a window.
- There is no backpressure. The consumer must accept every valid.

Test Plan:
- Reset, trigger every 100 cycles. Drive A high for 40 cycles starting 10 cycles after trigger, B low -> duty_source_valid is high exactly 1 cycle after the following trigger, data = 0x0028. No valid after the first post-reset trigger.
- Same, but B high for 25 cycles, A low -> data = 0xFFE7 (-25). Status flags stay 0.
- A high for 30 cycles and B high for 10 cycles in one window, no overlap -> data = 0x0014 (+20).
- A and B overlap high for 3 cycles -> status_shoot_through rises 3 cycles after the first overlapping input edge (2 sync + 1 register) and stays high through later windows. The overlap cycles are excluded from both counts.
- Open a window, then withhold trigger for 200 cycles -> status_overrun pulses once at cycle 200, no valid. The next trigger produces no valid; the trigger after it produces a normal valid.
- A held high continuously, trigger period 100 -> every window data = 0x0064. Assert reset for 1 cycle mid-window -> all outputs 0, no valid at the next trigger.
